// File: rtl/reset_req_sequencer.sv
// Merges power-on, software and error reset requests into one fifo_rst_n pulse and tracks per-domain acknowledges.
// Latency: a request in IDLE lowers fifo_rst_n next cycle; no backpressure, requests arriving while busy are latched and merged.
module reset_req_sequencer #(
    parameter int PULSE_CYCLES   = 16,
    parameter int ACK_TIMEOUT    = 64,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int NUM_DOMAINS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_sw,
    input  logic                   req_err,
    input  logic [NUM_DOMAINS-1:0] dom_ack,
    output logic                   fifo_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [2:0]             cause
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + ACK_TIMEOUT + HOLDOFF_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ASSERT_LIMIT = CNT_W'(PULSE_CYCLES - 1 + ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_HOLDOFF
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   pend_sw_q, pend_sw_d;
    logic                   pend_err_q, pend_err_d;
    logic                   timeout_q, timeout_d;
    logic [2:0]             cause_q, cause_d;
    logic                   fifo_rst_n_q, fifo_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_DOMAINS-1:0] ack_meta_q, ack_meta_d;
    logic [NUM_DOMAINS-1:0] ack_s_q, ack_s_d;
    logic                   all_lo;
    logic                   all_hi;
    logic                   start_req;

    // dom_ack is asynchronous to clk: two flops per bit before the FSM looks at it
    always_comb begin
        ack_meta_d = dom_ack;
        ack_s_d    = ack_meta_q;
    end

    assign all_lo    = (ack_s_q == '0);
    assign all_hi    = (ack_s_q == '1);
    assign start_req = pend_sw_q | pend_err_q | req_sw | req_err;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_sw_d  = pend_sw_q | req_sw;
        pend_err_d = pend_err_q | req_err;
        timeout_d  = timeout_q;
        cause_d    = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d    = ST_ASSERT;
                    cause_d    = {pend_err_q | req_err, pend_sw_q | req_sw, 1'b0};
                    pend_sw_d  = 1'b0;
                    pend_err_d = 1'b0;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                end
            end
            ST_ASSERT: begin
                cnt_d = cnt_inc;
                if ((cnt_q >= PULSE_LAST) && all_lo) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q >= ASSERT_LIMIT) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_inc;
                if (all_hi) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else if (cnt_q >= RELEASE_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_HOLDOFF: begin
                cnt_d = cnt_inc;
                if (cnt_q >= HOLDOFF_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q
        fifo_rst_n_d = (state_d != ST_ASSERT);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_q == ST_RELEASE) && (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            pend_sw_q    <= 1'b0;
            pend_err_q   <= 1'b0;
            timeout_q    <= 1'b0;
            cause_q      <= 3'b001;
            fifo_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            ack_meta_q   <= '1;
            ack_s_q      <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_sw_q    <= pend_sw_d;
            pend_err_q   <= pend_err_d;
            timeout_q    <= timeout_d;
            cause_q      <= cause_d;
            fifo_rst_n_q <= fifo_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ack_meta_q   <= ack_meta_d;
            ack_s_q      <= ack_s_d;
        end
    end

    assign fifo_rst_n = fifo_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign cause      = cause_q;

endmodule
